sync_fifo_gen: RTL and testbench
================================

Name: sync_fifo_gen

Overview:
Parametrised successor to the team's fixed 16x8 synchronous FIFO. It supports any depth of 2 or more, including non-power-of-two, with wrap-around pointers. It adds programmable almost-full/almost-empty thresholds, an occupancy count output, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between single-clock producer and consumer datapaths and is the default buffer for new blocks.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out
DEPTH, 8, number of entries; legal range >= 2, any integer
CNT_WIDTH, $clog2(DEPTH+1), width of count; derived, not overridden
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of contents; active high
write_en  in  1  write request
data_in  in  DATA_WIDTH  write data
read_en  in  1  read request
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected
count  out  CNT_WIDTH  current occupancy

Behaviour:
- Reset (reset_n=0 at edge): wr_ptr, rd_ptr, count = 0; data_out = 0; overflow, underflow = 0. Flags follow count: empty=1, almost_empty=1, full=0, almost_full=0. Storage array is not reset.
- Priority per edge: reset_n, then flush, then read/write.
- flush: same clear as reset; any write_en/read_en in that cycle is ignored; no overflow/underflow pulse.
- Write accept: write_en && (!full || read accepted this cycle). Data goes to mem[wr_ptr]; wr_ptr advances. wr_ptr wraps from DEPTH-1 to 0.
- Read accept: read_en && !empty. rd_ptr advances with the same wrap rule.
- Full with write_en && read_en: both are accepted; count unchanged; no overflow.
- Empty with write_en && read_en: write accepted; read rejected with underflow=1; count becomes 1. This holds in both modes.
- Rejected write (write_en && full && no read): data is dropped; overflow=1 for exactly the following cycle. State is unchanged.
- Rejected read (read_en && empty): underflow=1 for the following cycle. data_out holds its value (FWFT=0).
- count: +1 on write-only accept; -1 on read-only accept; unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- All flags and count are derived from registered state. They reflect the cycle after the causing edge and never combinationally depend on write_en/read_en.
- FWFT=0: on an accepted read, data_out <= mem[rd_ptr] at that edge, giving 1-cycle latency. Otherwise data_out holds.
- FWFT=1: data_out = mem[rd_ptr] whenever !empty; 0 when empty. read_en acts as pop, and the next word appears the cycle after the pop. A word written into an empty FIFO is visible on data_out the cycle after its write.
- Ordering: strict FIFO across pointer wrap for all DEPTH values.
- Reset mid-operation: contents are lost. The first write after reset is the first word read.

Test Plan:
- Reset/flags, DEPTH=8, AF=6, AE=2: after reset, count=0, empty=1, ae=1. Write 0x0001..0x0006 → after the 6th write count=6, almost_full=1, almost_empty=0, full=0. Two more writes → full=1.
- Overflow: FIFO full, write 0xDEAD → overflow pulse of 1 cycle; count stays 8. Read all 8 → 0x0001..0x0008 in order, 0xDEAD absent, empty=1.
- Underflow and simultaneous: empty FIFO, read_en=1 → underflow pulse, data_out unchanged. Full FIFO, write_en=read_en=1 with 0xBEEF → count stays 8, no overflow; 0xBEEF exits last.
- Wrap, DEPTH=5 (non-power-of-two): 20 cycles of interleaved writes of an incrementing pattern and reads keeping count 2..4 → all values read in order. Pointers wrap 4→0 with no lost or duplicated words.
- FWFT=1: write 0x00A5 into empty FIFO → data_out=0x00A5 the next cycle without read_en. Pop → empty=1 and data_out=0.
- Flush/reset mid-stream: with count=5, flush=1 together with write_en=1 → count=0, empty=1, no overflow. Repeat using reset_n=0 → same result, plus data_out=0.

Source files
------------

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO.
// Any DEPTH >= 2, including non-power-of-two, using wrap-around pointers.
// Provides almost-full and almost-empty thresholds, an occupancy count,
// a synchronous flush, overflow/underflow pulses, and a choice of
// registered or first-word-fall-through read.
module sync_fifo_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0]     PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

    // Parameter legality is checked at elaboration. This stops a bad instance
    // before it can silently misbehave.
    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_gen: DEPTH must be >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_gen: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_gen: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;
    logic                  af_q,     af_d;
    logic                  ae_q,     ae_d;

    logic rd_acc;
    logic wr_acc;
    logic mem_we;

    // Pointer increment with an explicit wrap.
    // A power-of-two rollover cannot be used because DEPTH may be any integer.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // Accept decisions use only registered flags.
    // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = read_en && !empty_q;
        wr_acc = write_en && (!full_q || rd_acc);
        mem_we = reset_n && !flush && wr_acc;
    end

    // Next-state logic for the pointers, the count, the read data and the pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                if (!FWFT) begin
                    dout_d = mem[rd_ptr_q];
                end
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase

            ovf_d = write_en && !wr_acc;
            udf_d = read_en && empty_q;
        end
    end

    // Flags are registered from the next count.
    // They are therefore glitch-free, and they never depend on this cycle's requests.
    always_comb begin
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
        end
    end

    // Storage write. The array is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Output mux.
    // FWFT shows the head word whenever the FIFO is non-empty.
    // Registered mode presents the word captured at the last accepted read.
    always_comb begin
        if (FWFT) begin
            data_out = empty_q ? '0 : mem[rd_ptr_q];
        end else begin
            data_out = dout_q;
        end
        full         = full_q;
        empty        = empty_q;
        almost_full  = af_q;
        almost_empty = ae_q;
        overflow     = ovf_q;
        underflow    = udf_q;
        count        = count_q;
    end

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Bench for sync_fifo_gen.
// Three instances share one stimulus stream:
//   - DEPTH 8, registered read
//   - DEPTH 5, registered read
//   - DEPTH 8, FWFT
// Each instance is compared every cycle against a queue-based reference model.
module tb_sync_fifo_gen;

    logic        clk = 1'b0;
    logic        reset_n, flush, write_en, read_en;
    logic [15:0] data_in;

    logic [15:0] dout [3];
    logic        full [3], empty [3], afl [3], ael [3], ovf [3], udf [3];
    logic [3:0]  cnt0, cnt2;
    logic [2:0]  cnt1;

    always #5 clk = ~clk;

    sync_fifo_gen #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_d8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(dout[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(afl[0]), .almost_empty(ael[0]), .overflow(ovf[0]), .underflow(udf[0]),
        .count(cnt0));

    sync_fifo_gen #(.DATA_WIDTH(16), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b0)) u_d5 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(dout[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(afl[1]), .almost_empty(ael[1]), .overflow(ovf[1]), .underflow(udf[1]),
        .count(cnt1));

    sync_fifo_gen #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_fw (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(dout[2]), .full(full[2]), .empty(empty[2]),
        .almost_full(afl[2]), .almost_empty(ael[2]), .overflow(ovf[2]), .underflow(udf[2]),
        .count(cnt2));

    // Reference model: one queue per instance plus the registered outputs.
    int          dep [3] = '{8, 5, 8};
    int          aft [3] = '{6, 4, 6};
    int          aet [3] = '{2, 1, 2};
    bit          fw  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] mq  [3][$];
    logic [15:0] m_dout [3];
    bit          m_ovf [3], m_udf [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h expected %0h at t=%0t", tag, idx, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int sz;
        bit ra, wa;
        logic [15:0] w;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n || flush) begin
                mq[i].delete();
                m_dout[i] = '0;
                m_ovf[i]  = 1'b0;
                m_udf[i]  = 1'b0;
            end else begin
                sz = mq[i].size();
                ra = read_en && (sz > 0);
                wa = write_en && ((sz < dep[i]) || ra);
                m_ovf[i] = write_en && !wa;
                m_udf[i] = read_en && (sz == 0);
                if (ra) begin
                    w = mq[i].pop_front();
                    if (!fw[i]) m_dout[i] = w;
                end
                if (wa) mq[i].push_back(data_in);
            end
        end
    endtask

    task automatic check_all();
        int sz;
        logic [31:0] c;
        logic [15:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            sz = mq[i].size();
            c  = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
            chk("count",        i, c,              32'(sz));
            chk("empty",        i, 32'(empty[i]),  32'(sz == 0));
            chk("full",         i, 32'(full[i]),   32'(sz == dep[i]));
            chk("almost_full",  i, 32'(afl[i]),    32'(sz >= aft[i]));
            chk("almost_empty", i, 32'(ael[i]),    32'(sz <= aet[i]));
            chk("overflow",     i, 32'(ovf[i]),    32'(m_ovf[i]));
            chk("underflow",    i, 32'(udf[i]),    32'(m_udf[i]));
            if (fw[i]) exp_d = (sz > 0) ? mq[i][0] : 16'h0000;
            else       exp_d = m_dout[i];
            chk("data_out",     i, 32'(dout[i]),   32'(exp_d));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit rn, input bit fl, input bit we, input bit re, input logic [15:0] d);
        reset_n  = rn;
        flush    = fl;
        write_en = we;
        read_en  = re;
        data_in  = d;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
        tick();
        drive(0, 0, 0, 0, 16'h0);

        // Fill through almost-full to full, then attempt an overflow write.
        for (int v = 1; v <= 8; v++) drive(1, 0, 1, 0, 16'(v));
        drive(1, 0, 1, 0, 16'hDEAD);
        drive(1, 0, 0, 0, 16'h0);

        // Drain completely, then read while empty.
        for (int v = 0; v < 8; v++) drive(1, 0, 0, 1, 16'h0);
        drive(1, 0, 0, 1, 16'h0);
        drive(1, 0, 0, 0, 16'h0);

        // Write and read together on a full FIFO; 0xBEEF must exit last.
        for (int v = 0; v < 8; v++) drive(1, 0, 1, 0, 16'h0010 + 16'(v));
        drive(1, 0, 1, 1, 16'hBEEF);
        for (int v = 0; v < 9; v++) drive(1, 0, 0, 1, 16'h0);

        // Write and read together on an empty FIFO.
        drive(1, 0, 1, 1, 16'h0077);
        drive(1, 0, 0, 1, 16'h0);

        // Fall-through visibility: one write, one idle cycle, then a pop.
        drive(1, 0, 1, 0, 16'h00A5);
        drive(1, 0, 0, 0, 16'h0);
        drive(1, 0, 0, 1, 16'h0);
        drive(1, 0, 0, 0, 16'h0);

        // Interleaved traffic that keeps the occupancy in 2..4 and wraps the depth-5 pointers.
        for (int v = 0; v < 3; v++) drive(1, 0, 1, 0, 16'h0100 + 16'(v));
        for (int v = 0; v < 20; v++) begin
            if (v % 2 == 0) drive(1, 0, 1, 0, 16'h0103 + 16'(v / 2));
            else            drive(1, 0, 0, 1, 16'h0);
        end
        for (int v = 0; v < 10; v++) drive(1, 0, 0, 1, 16'h0);

        // Flush with five entries and a simultaneous write, then the same with reset.
        for (int v = 0; v < 5; v++) drive(1, 0, 1, 0, 16'h0200 + 16'(v));
        drive(1, 0, 1, 1, 16'h0300);
        drive(1, 1, 1, 0, 16'h0301);
        drive(1, 0, 0, 0, 16'h0);
        for (int v = 0; v < 5; v++) drive(1, 0, 1, 0, 16'h0400 + 16'(v));
        drive(1, 0, 0, 1, 16'h0);
        drive(0, 0, 1, 0, 16'h0401);
        drive(1, 0, 1, 0, 16'h0500);
        drive(1, 0, 0, 1, 16'h0);

        // Random traffic in alternating write-heavy and read-heavy phases,
        // so that both full and empty are reached repeatedly.
        for (int v = 0; v < 3000; v++) begin
            int wp;
            wp = ((v / 150) % 2 == 0) ? 70 : 30;
            drive(($urandom_range(0, 999) >= 4),
                  ($urandom_range(0, 999) < 8),
                  ($urandom_range(0, 99) < wp),
                  ($urandom_range(0, 99) < 100 - wp),
                  16'($urandom));
        end
        drive(1, 0, 0, 0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
